// File: rtl/udp_event_capture_pkg.sv
// Shared definitions for the UDP event capture block: FSM state encodings
// and default widths for the window length and result counters.
package udp_event_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } cap_state_t;

   localparam int WIN_W_DEF = 8;
   localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/udp_sat_counter.sv
// Saturating up-counter with synchronous clear. sat_hit flags an increment
// request that arrives while the counter is already at all-ones.
module udp_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] value,
   output logic             sat_hit
);

   logic [CNT_W-1:0] value_q;
   logic [CNT_W-1:0] value_d;
   logic             at_max;

   assign at_max  = &value_q;
   assign sat_hit = inc & at_max;
   assign value   = value_q;

   // Next value: clear wins, otherwise increment unless already saturated
   always_comb begin
      value_d = value_q;
      if (clear) begin
         value_d = '0;
      end else if (inc && !at_max) begin
         value_d = value_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

endmodule

// File: rtl/udp_event_capture.sv
// Measurement stage behind the UDP logic circuit: registers e and f, then over
// a programmed window counts rising edges of f and high cycles of e, and
// presents both counts to a reader through a valid/ready handshake.
module udp_event_capture
   import udp_event_capture_pkg::*;
#(
   parameter int WIN_W = WIN_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             e_in,
   input  logic             f_in,
   input  logic             start,
   input  logic [WIN_W-1:0] win_len,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] rise_cnt,
   output logic [CNT_W-1:0] high_cnt,
   output logic             overflow
);

   cap_state_t       state_q, state_d;
   logic [WIN_W-1:0] remaining_q, remaining_d;
   logic             overflow_q, overflow_d;
   logic             e_q, f_q, f_prev_q;
   logic             rise;
   logic             cnt_clear;
   logic             cnt_en;
   logic             rise_sat, high_sat;

   // f history is never cleared, so a rise straddling the window start counts
   assign rise = f_q & ~f_prev_q;

   // Free-running input sampling and edge-detect history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q      <= 1'b0;
         f_q      <= 1'b0;
         f_prev_q <= 1'b0;
      end else begin
         e_q      <= e_in;
         f_q      <= f_in;
         f_prev_q <= f_q;
      end
   end

   // Window FSM: next state, window countdown, counter control, sticky overflow
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      overflow_d  = overflow_q;
      cnt_clear   = 1'b0;
      cnt_en      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_clear  = 1'b1;
               overflow_d = 1'b0;
               if (win_len != '0) begin
                  state_d     = ST_COUNT;
                  remaining_d = win_len;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_COUNT: begin
            cnt_en      = 1'b1;
            remaining_d = remaining_q - 1'b1;
            if (rise_sat || high_sat) begin
               overflow_d = 1'b1;
            end
            if (remaining_q == WIN_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM, window counter and overflow registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         overflow_q  <= overflow_d;
      end
   end

   udp_sat_counter #(.CNT_W(CNT_W)) u_rise_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear   (cnt_clear),
      .inc     (cnt_en & rise),
      .value   (rise_cnt),
      .sat_hit (rise_sat)
   );

   udp_sat_counter #(.CNT_W(CNT_W)) u_high_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear   (cnt_clear),
      .inc     (cnt_en & e_q),
      .value   (high_cnt),
      .sat_hit (high_sat)
   );

   assign busy      = (state_q == ST_COUNT);
   assign res_valid = (state_q == ST_DONE);
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_udp_event_capture.sv
// Directed bench for udp_event_capture (CNT_W=4 so saturation is reachable).
module tb_udp_event_capture;

   localparam int WIN_W = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             e_in = 1'b0;
   logic             f_in = 1'b0;
   logic             start = 1'b0;
   logic [WIN_W-1:0] win_len = '0;
   logic             busy;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [CNT_W-1:0] rise_cnt;
   logic [CNT_W-1:0] high_cnt;
   logic             overflow;

   logic tog_en = 1'b0;
   int   checks = 0;
   int   failures = 0;

   udp_event_capture #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .e_in      (e_in),
      .f_in      (f_in),
      .start     (start),
      .win_len   (win_len),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .rise_cnt  (rise_cnt),
      .high_cnt  (high_cnt),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   // Advance one clock; inputs change 1ns after the edge, outputs sampled there too
   task automatic step();
      @(posedge clk);
      #1;
      if (tog_en) f_in = ~f_in;
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
   endtask

   initial begin
      // Power-on reset state
      step();
      step();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(res_valid), 0);
      chk("rst_rise", 32'(rise_cnt), 0);
      chk("rst_high", 32'(high_cnt), 0);
      chk("rst_ovf", 32'(overflow), 0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Basic window: f toggles every cycle, e held high
      e_in = 1'b1;
      tog_en = 1'b1;
      repeat (3) step();
      start = 1'b1;
      win_len = 8'd8;
      step();
      start = 1'b0;
      chk("basic_busy", 32'(busy), 1);
      for (int i = 0; i < 7; i++) begin
         step();
         chk("basic_wait_valid", 32'(res_valid), 0);
      end
      step();
      chk("basic_valid", 32'(res_valid), 1);
      chk("basic_busy_done", 32'(busy), 0);
      chk("basic_rise", 32'(rise_cnt), 4);
      chk("basic_high", 32'(high_cnt), 8);
      chk("basic_ovf", 32'(overflow), 0);
      handshake();
      chk("basic_valid_drop", 32'(res_valid), 0);

      // Saturation: 20 high cycles into a 4-bit counter
      tog_en = 1'b0;
      f_in = 1'b0;
      e_in = 1'b1;
      repeat (2) step();
      start = 1'b1;
      win_len = 8'd20;
      step();
      start = 1'b0;
      repeat (20) step();
      chk("sat_valid", 32'(res_valid), 1);
      chk("sat_high", 32'(high_cnt), 15);
      chk("sat_rise", 32'(rise_cnt), 0);
      chk("sat_ovf", 32'(overflow), 1);
      handshake();
      chk("sat_held_ovf", 32'(overflow), 1);

      // Empty window: straight to DONE with cleared results
      start = 1'b1;
      win_len = 8'd0;
      step();
      start = 1'b0;
      chk("empty_valid", 32'(res_valid), 1);
      chk("empty_busy", 32'(busy), 0);
      chk("empty_rise", 32'(rise_cnt), 0);
      chk("empty_high", 32'(high_cnt), 0);
      chk("empty_ovf", 32'(overflow), 0);
      handshake();

      // Handshake stall, then ready with a coincident start that must be ignored
      start = 1'b1;
      win_len = 8'd4;
      step();
      start = 1'b0;
      repeat (4) step();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hs_stall_valid", 32'(res_valid), 1);
         chk("hs_stall_high", 32'(high_cnt), 4);
      end
      res_ready = 1'b1;
      start = 1'b1;
      win_len = 8'd3;
      step();
      res_ready = 1'b0;
      start = 1'b0;
      chk("hs_valid_drop", 32'(res_valid), 0);
      chk("hs_busy", 32'(busy), 0);
      step();
      chk("hs_busy_after", 32'(busy), 0);
      chk("hs_idle_held_high", 32'(high_cnt), 4);

      // Start during COUNT is ignored; window stays 6 cycles
      e_in = 1'b0;
      tog_en = 1'b1;
      repeat (2) step();
      start = 1'b1;
      win_len = 8'd6;
      step();
      start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         if (i == 2) begin
            start = 1'b1;
            win_len = 8'd2;
         end
         step();
         start = 1'b0;
         chk("ign_wait_valid", 32'(res_valid), 0);
      end
      step();
      chk("ign_valid", 32'(res_valid), 1);
      chk("ign_rise", 32'(rise_cnt), 3);
      chk("ign_high", 32'(high_cnt), 0);
      handshake();

      // Asynchronous reset in the middle of a window
      e_in = 1'b1;
      repeat (2) step();
      start = 1'b1;
      win_len = 8'd8;
      step();
      start = 1'b0;
      repeat (3) step();
      chk("mid_busy", 32'(busy), 1);
      chk("mid_high", 32'(high_cnt), 3);
      rst = 1'b1;
      #2;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_valid", 32'(res_valid), 0);
      chk("arst_rise", 32'(rise_cnt), 0);
      chk("arst_high", 32'(high_cnt), 0);
      chk("arst_ovf", 32'(overflow), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("post_rst_busy", 32'(busy), 0);
         chk("post_rst_valid", 32'(res_valid), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
